// File: rtl/uart_alu_pkg.sv
// Shared types and helpers for the UART/ALU frame controller.
package uart_alu_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    RX_OPC,
    RX_A,
    RX_B,
    EXEC,
    TX
  } state_e;

  function automatic int unsigned bytes(input int unsigned n);
    return n / BYTE_W;
  endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// Idle counter with synchronous clear and enable.
// o_tc is high during the TIMEOUT_CYC-th consecutive enabled cycle.
module uart_alu_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tc = i_enable && !i_clear && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || o_tc) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller between UART RX/TX FIFOs and an ALU: opcode + A + B in, result out, LSB first.
// Optional inter-byte timeout on partial frames when UART_ALU_TIMEOUT_EN is defined.
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned OPC_N       = 6,
  parameter int unsigned ALU_LAT     = 1,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_empty,
  output logic             o_rx_rd,
  output logic [N-1:0]     o_alu_a,
  output logic [N-1:0]     o_alu_b,
  output logic [OPC_N-1:0] o_alu_opc,
  input  logic [N-1:0]     i_alu_result,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_wr,
  input  logic             i_tx_full,
  output logic             o_busy,
  output logic [15:0]      o_frame_cnt,
  output logic             o_timeout_err
);

  localparam int unsigned NB      = bytes(N);
  localparam logic [3:0]  LAST_BC = 4'(NB - 1);

  state_e           state_q, state_d;
  logic [3:0]       bc_q, bc_d;
  logic [3:0]       lat_q, lat_d;
  logic [OPC_N-1:0] opc_sh_q, opc_sh_d, alu_opc_q;
  logic [N-1:0]     a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [N-1:0]     alu_a_q, alu_b_q, shift_q;
  logic [15:0]      frame_cnt_q;
  logic             rx_pop, tx_push, last_bc;
  logic             load_alu, load_res, frame_done, timeout;

  assign last_bc = (bc_q == LAST_BC);

  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    lat_d      = lat_q;
    opc_sh_d   = opc_sh_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;
    load_alu   = 1'b0;
    load_res   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      RX_OPC: begin
        rx_pop = !i_rx_empty;
        if (rx_pop) begin
          opc_sh_d = i_rx_data[OPC_N-1:0];
          state_d  = RX_A;
        end
      end
      RX_A: begin
        rx_pop = !i_rx_empty;
        if (rx_pop) begin
          a_sh_d[bc_q*BYTE_W +: BYTE_W] = i_rx_data;
          bc_d = last_bc ? 4'd0 : bc_q + 4'd1;
          if (last_bc) state_d = RX_B;
        end
      end
      RX_B: begin
        rx_pop = !i_rx_empty;
        if (rx_pop) begin
          b_sh_d[bc_q*BYTE_W +: BYTE_W] = i_rx_data;
          bc_d = last_bc ? 4'd0 : bc_q + 4'd1;
          if (last_bc) begin
            // Final byte goes straight through to the ALU outputs on the same edge.
            state_d  = EXEC;
            load_alu = 1'b1;
            lat_d    = 4'd0;
          end
        end
      end
      EXEC: begin
        if (lat_q == 4'(ALU_LAT)) begin
          load_res = 1'b1;
          bc_d     = 4'd0;
          state_d  = TX;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      TX: begin
        tx_push = !i_tx_full;
        if (tx_push) begin
          bc_d = last_bc ? 4'd0 : bc_q + 4'd1;
          if (last_bc) begin
            frame_done = 1'b1;
            state_d    = RX_OPC;
          end
        end
      end
      default: state_d = RX_OPC;
    endcase
    if (timeout) begin
      state_d = RX_OPC;
      bc_d    = 4'd0;
    end
  end

`ifdef UART_ALU_TIMEOUT_EN
  logic in_ab;
  assign in_ab = (state_q == RX_A) || (state_q == RX_B);

  uart_alu_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (!in_ab || rx_pop),
    .i_enable(in_ab && i_rx_empty),
    .o_tc    (timeout)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= RX_OPC;
      bc_q        <= '0;
      lat_q       <= '0;
      opc_sh_q    <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      alu_opc_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      shift_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      lat_q    <= lat_d;
      opc_sh_q <= opc_sh_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      if (load_alu) begin
        alu_opc_q <= opc_sh_d;
        alu_a_q   <= a_sh_d;
        alu_b_q   <= b_sh_d;
      end
      if (load_res) begin
        shift_q <= i_alu_result;
      end else if (tx_push) begin
        shift_q <= shift_q >> BYTE_W;
      end
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Gated with reset so nothing moves through either FIFO while reset is held.
  assign o_rx_rd       = rx_pop && !i_reset;
  assign o_tx_wr       = tx_push && !i_reset;
  assign o_tx_data     = shift_q[7:0];
  assign o_alu_a       = alu_a_q;
  assign o_alu_b       = alu_b_q;
  assign o_alu_opc     = alu_opc_q;
  assign o_busy        = (state_q != RX_OPC);
  assign o_frame_cnt   = frame_cnt_q;
  assign o_timeout_err = timeout;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed bench: an N=8 and an N=16 instance fed from byte FIFO models, ALU model is a+b.
module tb_uart_alu_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // N=8 instance signals
  logic [7:0]  rxd8 = 8'h00;
  logic        rxe8 = 1'b1;
  logic        rd8, wr8, busy8, to8;
  logic        txf8 = 1'b0;
  logic [7:0]  a8, b8, res8, txd8;
  logic [5:0]  opc8;
  logic [15:0] fc8;

  // N=16 instance signals
  logic [7:0]  rxd16 = 8'h00;
  logic        rxe16 = 1'b1;
  logic        txf16 = 1'b0;
  logic        rd16, wr16, busy16, to16;
  logic [15:0] a16, b16, res16, fc16;
  logic [7:0]  txd16;
  logic [5:0]  opc16;

  assign res8  = a8 + b8;
  assign res16 = a16 + b16;

  uart_alu_frame_ctrl #(
    .N(8), .OPC_N(6), .ALU_LAT(1), .TIMEOUT_CYC(20)
  ) u_dut8 (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rxd8), .i_rx_empty(rxe8), .o_rx_rd(rd8),
    .o_alu_a(a8), .o_alu_b(b8), .o_alu_opc(opc8), .i_alu_result(res8),
    .o_tx_data(txd8), .o_tx_wr(wr8), .i_tx_full(txf8), .o_busy(busy8),
    .o_frame_cnt(fc8), .o_timeout_err(to8)
  );

  uart_alu_frame_ctrl #(
    .N(16), .OPC_N(6), .ALU_LAT(1), .TIMEOUT_CYC(20)
  ) u_dut16 (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rxd16), .i_rx_empty(rxe16), .o_rx_rd(rd16),
    .o_alu_a(a16), .o_alu_b(b16), .o_alu_opc(opc16), .i_alu_result(res16),
    .o_tx_data(txd16), .o_tx_wr(wr16), .i_tx_full(txf16), .o_busy(busy16),
    .o_frame_cnt(fc16), .o_timeout_err(to16)
  );

  // FIFO models: stimulus writes rxm/wp, monitors own rp/txm/txn.
  logic [7:0] rxm8 [64];
  logic [7:0] rxm16[64];
  logic [7:0] txm8 [64];
  logic [7:0] txm16[64];
  int wp8 = 0, rp8 = 0, txn8 = 0, cyc8 = 0;
  int wp16 = 0, rp16 = 0, txn16 = 0;
  int pops16 = 0, viol16 = 0, ab_chg16 = 0, to_cnt16 = 0;
  logic        full_req16 = 1'b0;
  logic [31:0] ab_prev16 = 32'h0;
  logic        s_rd8, s_wr8, s_rd16, s_wr16;
  logic [7:0]  s_d8, s_d16;

  always begin
    @(negedge clk); #1;
    s_rd8 = rd8; s_wr8 = wr8; s_d8 = txd8;
    if (rd8 || busy8) cyc8++;
    @(posedge clk); #1;
    if (s_rd8) rp8++;
    if (s_wr8 && txn8 < 64) begin txm8[txn8] = s_d8; txn8++; end
    rxd8 = rxm8[rp8 % 64];
    rxe8 = (rp8 == wp8);
  end

  always begin
    @(negedge clk); #1;
    s_rd16 = rd16; s_wr16 = wr16; s_d16 = txd16;
    if (rd16) pops16++;
    if (rd16 && rxe16) viol16++;
    if (to16) to_cnt16++;
    if ({a16, b16} != ab_prev16) begin ab_chg16++; ab_prev16 = {a16, b16}; end
    @(posedge clk); #1;
    if (s_rd16) rp16++;
    if (s_wr16 && txn16 < 64) begin txm16[txn16] = s_d16; txn16++; end
    rxd16 = rxm16[rp16 % 64];
    rxe16 = (rp16 == wp16);
    txf16 = full_req16;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push8(input logic [7:0] b);
    rxm8[wp8 % 64] = b;
    wp8++;
  endtask

  task automatic push16(input logic [7:0] b);
    rxm16[wp16 % 64] = b;
    wp16++;
  endtask

  task automatic frame16(input logic [7:0] o, a0, a1, b0, b1);
    push16(o); push16(a0); push16(a1); push16(b0); push16(b1);
  endtask

  task automatic wait_tx8(input int target);
    int n = 0;
    while (txn8 < target && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic wait_tx16(input int target);
    int n = 0;
    while (txn16 < target && n < 200) begin @(negedge clk); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, t0, p0, fcb, tob, to_at, stall_wr, stall_chg, n;
    logic [7:0] d0;

    repeat (3) @(negedge clk);
    check("rst_busy16", busy16, 0);
    check("rst_a16", a16, 0);
    check("rst_b16", b16, 0);
    check("rst_opc16", opc16, 0);
    check("rst_txd16", txd16, 0);
    check("rst_wr16", wr16, 0);
    check("rst_rd16", rd16, 0);
    check("rst_fc16", fc16, 0);
    check("rst_to16", to16, 0);
    check("rst_to8", to8, 0);
    rst = 1'b0;
    @(negedge clk);

    // N=8 single frame: 1 + 5 = 6? opcode 1, a=5, b=3
    base = cyc8;
    push8(8'h01); push8(8'h05); push8(8'h03);
    wait_tx8(1);
    repeat (3) @(negedge clk);
    check("n8_opc", opc8, 8'h01);
    check("n8_a", a8, 8'h05);
    check("n8_b", b8, 8'h03);
    check("n8_tx0", txm8[0], 8'h08);
    check("n8_txn", txn8, 1);
    check("n8_fc", fc8, 1);
    check("n8_cycles", cyc8 - base, 6);

    // N=16 back-to-back: a=0x1234, b=0x0001, result 0x1235
    base = ab_chg16; t0 = txn16;
    frame16(8'h02, 8'h34, 8'h12, 8'h01, 8'h00);
    wait_tx16(t0 + 2);
    repeat (3) @(negedge clk);
    check("n16_opc", opc16, 6'h02);
    check("n16_a", a16, 16'h1234);
    check("n16_b", b16, 16'h0001);
    check("n16_ab_one_step", ab_chg16 - base, 1);
    check("n16_tx0", txm16[t0], 8'h35);
    check("n16_tx1", txm16[t0 + 1], 8'h12);
    check("n16_txn", txn16 - t0, 2);
    check("n16_fc", fc16, 1);

    // TX back-pressure: a=0x2211, b=0x0101, result 0x2312
    full_req16 = 1'b1;
    t0 = txn16;
    frame16(8'h03, 8'h11, 8'h22, 8'h01, 8'h01);
    repeat (9) @(negedge clk);
    d0 = txd16; stall_wr = 0; stall_chg = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr16) stall_wr++;
      if (txd16 !== d0) stall_chg++;
    end
    check("stall_busy", busy16, 1);
    check("stall_data", d0, 8'h12);
    check("stall_no_wr", stall_wr, 0);
    check("stall_data_stable", stall_chg, 0);
    check("stall_no_push", txn16 - t0, 0);
    full_req16 = 1'b0;
    wait_tx16(t0 + 2);
    repeat (3) @(negedge clk);
    check("stall_tx0", txm16[t0], 8'h12);
    check("stall_tx1", txm16[t0 + 1], 8'h23);
    check("stall_txn", txn16 - t0, 2);
    check("stall_fc", fc16, 2);

    // Trickled RX bytes with 10-cycle gaps
    p0 = pops16; t0 = txn16;
    push16(8'h02); repeat (10) @(negedge clk);
    push16(8'h34); repeat (10) @(negedge clk);
    push16(8'h12); repeat (10) @(negedge clk);
    push16(8'h01); repeat (10) @(negedge clk);
    push16(8'h00);
    wait_tx16(t0 + 2);
    repeat (3) @(negedge clk);
    check("trk_pops", pops16 - p0, 5);
    check("trk_no_empty_pop", viol16, 0);
    check("trk_tx0", txm16[t0], 8'h35);
    check("trk_tx1", txm16[t0 + 1], 8'h12);
    check("trk_fc", fc16, 3);

    // Reset in the TX cycle after the first result byte is written
    t0 = txn16;
    frame16(8'h05, 8'h34, 8'h12, 8'h01, 8'h00);
    n = 0;
    while (!wr16 && n < 50) begin @(negedge clk); n++; end
    check("rst_mid_reached_tx", wr16, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_wr", wr16, 0);
    check("rst_mid_busy", busy16, 0);
    check("rst_mid_a", a16, 0);
    check("rst_mid_b", b16, 0);
    check("rst_mid_opc", opc16, 0);
    check("rst_mid_txd", txd16, 0);
    check("rst_mid_fc", fc16, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_one_byte", txn16 - t0, 1);
    t0 = txn16;
    frame16(8'h02, 8'h34, 8'h12, 8'h01, 8'h00);
    wait_tx16(t0 + 2);
    repeat (3) @(negedge clk);
    check("post_rst_tx0", txm16[t0], 8'h35);
    check("post_rst_tx1", txm16[t0 + 1], 8'h12);
    check("post_rst_fc", fc16, 1);

`ifdef UART_ALU_TIMEOUT_EN
    // Opcode plus one A byte, then starve RX until the frame is dropped
    fcb = fc16; tob = to_cnt16; to_at = -1;
    push16(8'h07); push16(8'hAA);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (to16 && to_at < 0) to_at = i;
    end
    check("to_cycle", to_at, 22);
    check("to_pulses", to_cnt16 - tob, 1);
    check("to_idle", busy16, 0);
    check("to_fc", fc16, fcb);
    check("to_a_kept", a16, 16'h1234);
    t0 = txn16;
    frame16(8'h02, 8'h34, 8'h12, 8'h01, 8'h00);
    wait_tx16(t0 + 2);
    repeat (3) @(negedge clk);
    check("to_next_tx0", txm16[t0], 8'h35);
    check("to_next_tx1", txm16[t0 + 1], 8'h12);
    check("to_next_fc", fc16, fcb + 1);
`else
    tob = 0; fcb = 0;
    check("no_timeout_pulses", to_cnt16, tob);
    check("no_timeout_fc_nonzero", fc16 != 16'(fcb), 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_alu_frame_ctrl.md
# uart_alu_frame_ctrl

- Parametrised frame controller between the UART RX/TX FIFOs and the ALU.
- Receives a frame from the RX FIFO: one opcode byte, then operand A and operand B, each N/8 bytes, least-significant byte first.
- Presents the stable operands to the ALU, waits a configurable ALU latency, then streams the N-bit result back to the TX FIFO LSB first.
- Adds byte-serial operands, TX back-pressure, a frame counter and an optional inter-byte timeout.

## Interface
- N, 8: operand/result width; multiple of 8, 8..64.
- OPC_N, 6: opcode width, ≤ 8; taken from the low bits of the opcode byte, upper bits ignored.
- ALU_LAT, 1: ALU result latency in cycles, 0..15.
- TIMEOUT_CYC, 1000: idle cycles before a partial frame is dropped. Used only with the timeout macro.
- i_clock  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  8  RX FIFO head, first-word fall-through
- i_rx_empty  in  1  RX FIFO empty
- o_rx_rd  out  1  pop RX FIFO
- o_alu_a  out  N  operand A
- o_alu_b  out  N  operand B
- o_alu_opc  out  OPC_N  opcode
- i_alu_result  in  N  ALU result
- o_tx_data  out  8  byte to TX FIFO
- o_tx_wr  out  1  push TX FIFO
- i_tx_full  in  1  TX FIFO full
- o_busy  out  1  frame in progress, i.e. state ≠ RX_OPC
- o_frame_cnt  out  16  completed frames, wraps at 0xFFFF→0
- o_timeout_err  out  1  one-cycle pulse when a frame is dropped

## Operation
States and transitions:
- RX_OPC → RX_A → RX_B → EXEC → TX → RX_OPC.
- Byte counter BC counts 0..N/8-1.

RX side:
- In RX_OPC, RX_A and RX_B, o_rx_rd = !i_rx_empty (combinational).
- The byte on i_rx_data is captured on the same edge as the pop.
- The opcode goes to an opcode shadow register. A and B bytes go into shadow registers at byte position BC.
- RX_A and RX_B advance to the next state when the byte with BC = N/8-1 is popped. BC then clears.
- Shadow registers transfer to o_alu_opc, o_alu_a and o_alu_b on the edge entering EXEC. These outputs then hold until the next frame's EXEC entry, so the ALU never sees partial operands.

EXEC:
- Lasts ALU_LAT+1 cycles.
- i_alu_result is captured into a TX shift register on the last EXEC edge.

TX side:
- In TX, o_tx_wr = !i_tx_full (combinational) and o_tx_data = shift register bits [7:0].
- Each write shifts the register right by 8 and increments BC.
- While i_tx_full is high, the controller holds: no write, no shift.
- After byte N/8-1 is written: o_frame_cnt increments and the state returns to RX_OPC.
- o_rx_rd is never high outside the RX states; o_tx_wr is never high outside TX.

Reset:
- All outputs are 0, state is RX_OPC, BC = 0, shadow and shift registers are 0.
- Reset mid-frame discards the partial frame. Nothing is popped or pushed during reset.

## Timing
- Fastest frame, FIFO never empty and never full: 1 + 2·N/8 RX cycles + (ALU_LAT+1) EXEC cycles + N/8 TX cycles.
- Example, N=8 and ALU_LAT=1: 6 cycles.
- Minimum latency from the last operand pop to the first o_tx_wr is ALU_LAT+1 cycles.
- RX stalls indefinitely on an empty FIFO, unless the timeout is compiled in. TX stalls indefinitely on a full FIFO.

## Configuration
- UART_ALU_TIMEOUT_EN defined:
  - A counter runs in RX_A and RX_B while i_rx_empty is high. It clears on every pop.
  - When it reaches TIMEOUT_CYC: the state goes to RX_OPC, BC clears, o_timeout_err pulses 1 cycle, and shadow registers are left as they are.
  - The ALU outputs and o_frame_cnt are not changed.
- Undefined: no counter; o_timeout_err is tied to 0. The port exists in both builds.

## Structure
- Package uart_alu_pkg holds:
  - the state enum (RX_OPC, RX_A, RX_B, EXEC, TX);
  - the constant BYTE_W = 8;
  - the BYTES = N/8 helper function.
- Natural sub-module: uart_alu_timeout, the idle counter with clear/enable and a terminal-count pulse. It is instantiated only under UART_ALU_TIMEOUT_EN.

## Test plan
- N=8, ALU_LAT=1, preload RX with 0x01, 0x05, 0x03; the bench ALU model computes result = a+b.
  - Expect o_alu_opc=0x01, a=0x05, b=0x03, one TX write of 0x08, o_frame_cnt=1, 6 cycles total.
- N=16: RX bytes 0x02, 0x34, 0x12, 0x01, 0x00.
  - Expect a=0x1234 and b=0x0001 applied together at EXEC entry (no intermediate values); TX bytes 0x35 then 0x12.
- N=16, i_tx_full held high for 5 cycles during TX.
  - Expect no o_tx_wr and o_tx_data stable during the stall, then both bytes in order with none lost or duplicated.
- RX bytes trickled with 10-cycle gaps.
  - Expect o_rx_rd exactly once per byte, no pop while i_rx_empty is high, and the result identical to the back-to-back case.
- Timeout build, TIMEOUT_CYC=20: send opcode plus one A byte, then starve RX.
  - Expect o_timeout_err pulse at idle cycle 20, state back to RX_OPC, o_frame_cnt unchanged. A following complete frame is processed correctly.
- Assert i_reset in the TX cycle after the first of 2 bytes is written.
  - Expect all outputs 0 immediately and no further o_tx_wr. The next frame starts cleanly from RX_OPC.
